// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int DEF_ADDR_W       = 32;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_RD_LAT       = 1;
    localparam int DEF_MAX_DATA_RUN = 4;

    // Run counter covers MAX_DATA_RUN up to 15; wait counter covers RD_LAT up to 4.
    localparam int RUN_W  = 4;
    localparam int WAIT_W = 2;

    // Data wins unless fetch is waiting and data has used up its run allowance.
    function automatic logic pick_data(input logic if_req, input logic d_req,
                                       input logic run_full);
        return d_req && !(if_req && run_full);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data ports with a bounded data-run counter.
// Latency: combinational select, run counter updates on the grant edge.
// Backpressure: none; the caller only asserts i_grant when the memory is free.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_grant,
    output logic o_win_port
);

    logic [RUN_W-1:0] r_run_cnt;
    logic             w_run_full;

    assign w_run_full = (r_run_cnt == RUN_W'(MAX_DATA_RUN));
    assign o_win_port = pick_data(i_if_req, i_d_req, w_run_full) ? PORT_D : PORT_IF;

    // Only data grants made over a waiting fetch extend the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt <= '0;
        end else if (i_grant) begin
            if ((o_win_port == PORT_D) && i_if_req) begin
                r_run_cnt <= w_run_full ? r_run_cnt : r_run_cnt + RUN_W'(1);
            end else begin
                r_run_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports.
// Latency: loads/fetches ack RD_LAT cycles after the grant edge, stores after 1; period RD_LAT+2 / 3.
// Backpressure: req/ack handshake; a losing requester simply holds req until its own ack.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LAT       = DEF_RD_LAT,
    parameter int MAX_DATA_RUN = DEF_MAX_DATA_RUN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_port;
    logic                r_store;
    logic [WAIT_W-1:0]   r_wait;
    logic                w_grant;
    logic                w_win_port;
    logic                w_access_done;

    assign w_grant       = (r_state == IDLE) && (if_req || d_req);
    assign w_access_done = r_store || (r_wait == WAIT_W'(RD_LAT - 1));

    mem_arb_pick #(
        .MAX_DATA_RUN (MAX_DATA_RUN)
    ) u_pick (
        .clk        (clk),
        .rst        (rst),
        .i_if_req   (if_req),
        .i_d_req    (d_req),
        .i_grant    (w_grant),
        .o_win_port (w_win_port)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_nxt = ACCESS;
            ACCESS:  if (w_access_done) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // mem_addr doubles as the latched transaction address and holds outside ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_port    <= PORT_IF;
            r_store   <= 1'b0;
            r_wait    <= '0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            mem_write <= 1'b0;
            busy      <= (w_state_nxt != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_port <= w_win_port;
                        r_wait <= '0;
                        if (w_win_port == PORT_D) begin
                            r_store   <= d_we;
                            mem_addr  <= d_addr;
                            mem_write <= d_we;
                            if (d_we) mem_wdata <= d_wdata;
                        end else begin
                            r_store  <= 1'b0;
                            mem_addr <= if_addr;
                        end
                    end
                end
                ACCESS: begin
                    if (w_access_done) begin
                        if (r_port == PORT_D) begin
                            d_ack <= 1'b1;
                            if (!r_store) d_rdata <= mem_rdata;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int RD_LAT  = 1;
    localparam int MAX_RUN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .RD_LAT       (RD_LAT),
        .MAX_DATA_RUN (MAX_RUN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Memory with combinational read: data valid in the same cycle as the address.
    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_if_acks = 0;
    int n_d_acks  = 0;
    int n_wr      = 0;
    bit rand_mode = 1'b0;
    bit reissue_d = 1'b0;

    // Reference model: one transaction at a time, timed from the grant edge.
    int            m_ack_at  = -1;
    int            m_free_at = 0;
    int            m_run     = 0;
    logic          m_port;
    logic          m_we;
    logic [DW-1:0] m_rd;
    logic          e_if_ack, e_d_ack, e_mem_write, e_busy;
    logic [DW-1:0] e_if_rdata, e_d_rdata, e_mem_wdata;
    logic [AW-1:0] e_mem_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_edge();
        logic dwin;
        int   lat;
        e_if_ack    = 1'b0;
        e_d_ack     = 1'b0;
        e_mem_write = 1'b0;
        if (rst) begin
            e_busy = 1'b0; e_if_rdata = '0; e_d_rdata = '0;
            e_mem_wdata = '0; e_mem_addr = '0;
            m_ack_at = -1; m_free_at = cyc + 1; m_run = 0;
            return;
        end
        if (cyc == m_ack_at) begin
            if (m_port) begin
                e_d_ack = 1'b1;
                if (!m_we) e_d_rdata = m_rd;
            end else begin
                e_if_ack   = 1'b1;
                e_if_rdata = m_rd;
            end
        end
        if (cyc >= m_free_at && (if_req || d_req)) begin
            dwin = d_req && !(if_req && m_run == MAX_RUN);
            if (dwin && if_req) m_run = (m_run < MAX_RUN) ? m_run + 1 : MAX_RUN;
            else                m_run = 0;
            m_port     = dwin;
            m_we       = dwin && d_we;
            e_mem_addr = dwin ? d_addr : if_addr;
            if (m_we) begin
                e_mem_write = 1'b1;
                e_mem_wdata = d_wdata;
                ref_mem[d_addr[7:0]] = d_wdata;
            end else begin
                m_rd = ref_mem[e_mem_addr[7:0]];
            end
            lat       = m_we ? 1 : RD_LAT;
            m_ack_at  = cyc + lat;
            m_free_at = cyc + lat + 2;
        end
        e_busy = (cyc < m_free_at - 1);
    endfunction

    task automatic new_fetch();
        if_req  = 1'b1;
        if_addr = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 63);
    endtask

    task automatic new_data();
        d_req   = 1'b1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 63);
        d_wdata = $urandom;
    endtask

    task automatic drive();
        if (if_ack) begin
            if (rand_mode && $urandom_range(0, 1) == 1) new_fetch();
            else if_req = 1'b0;
        end else if (rand_mode && !if_req && $urandom_range(0, 2) == 0) begin
            new_fetch();
        end
        if (d_ack) begin
            if (reissue_d || (rand_mode && $urandom_range(0, 1) == 1)) new_data();
            else d_req = 1'b0;
        end else if (rand_mode && !d_req && $urandom_range(0, 2) == 0) begin
            new_data();
        end
        if (rand_mode) rst = ($urandom_range(0, 149) == 0);
    endtask

    task automatic step();
        if (mem_write === 1'b1) mem[mem_addr[7:0]] = mem_wdata;
        @(posedge clk);
        model_edge();
        #1;
        check("if_ack",    if_ack,    e_if_ack);
        check("d_ack",     d_ack,     e_d_ack);
        check("if_rdata",  if_rdata,  e_if_rdata);
        check("d_rdata",   d_rdata,   e_d_rdata);
        check("mem_write", mem_write, e_mem_write);
        check("mem_addr",  mem_addr,  e_mem_addr);
        check("mem_wdata", mem_wdata, e_mem_wdata);
        check("busy",      busy,      e_busy);
        if (if_ack)    n_if_acks++;
        if (d_ack)     n_d_acks++;
        if (mem_write) n_wr++;
        cyc++;
        drive();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((if_req || d_req || busy) && k < budget) begin
            step();
            k++;
        end
        check("idle_reached", {31'b0, (if_req || d_req || busy)}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8]     = 32'hDEAD_BEEF;
        ref_mem[8] = 32'hDEAD_BEEF;

        // Reset held with both requests pending; grants only after release.
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_wdata = '0;
        step();
        step();
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        wait_idle(50);

        // Single fetch from word 8.
        if_req = 1'b1; if_addr = 32'd8;
        wait_idle(20);
        check("fetch_rdata", if_rdata, 32'hDEAD_BEEF);

        // Store then load at address 16.
        n_wr = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd16; d_wdata = 32'h1234_5678;
        wait_idle(20);
        check("store_wr_cycles", n_wr, 32'd1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd16;
        wait_idle(20);
        check("load_rdata", d_rdata, 32'h1234_5678);

        // Contention from the same cycle: data first, fetch next.
        begin
            int k = 0;
            n_if_acks = 0;
            if_req = 1'b1; if_addr = 32'h0000_1020;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2030;
            do begin
                step();
                k++;
            end while (!if_ack && !d_ack && k < 20);
            check("contend_first_d_ack", {31'b0, d_ack}, 32'd1);
            check("contend_first_if_ack", {31'b0, if_ack}, 32'd0);
            wait_idle(20);
            check("contend_fetch_done", n_if_acks, 32'd1);
        end

        // Starvation bound: data continuously re-issued, fetch held.
        begin
            int k = 0;
            n_if_acks = 0; n_d_acks = 0;
            reissue_d = 1'b1;
            if_req = 1'b1; if_addr = 32'h0000_3004;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3008;
            while (n_if_acks == 0 && k < 300) begin
                step();
                k++;
            end
            check("starve_data_run", n_d_acks, MAX_RUN);
            while (n_d_acks == MAX_RUN && k < 300) begin
                step();
                k++;
            end
            check("resume_data", n_d_acks, MAX_RUN + 1);
            check("resume_no_fetch", n_if_acks, 32'd1);
            reissue_d = 1'b0;
            wait_idle(50);
        end

        // Reset during a store's ACCESS cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0020; d_wdata = 32'hA5A5_0F0F;
        step();
        check("mid_store_wr", {31'b0, mem_write}, 32'd1);
        rst = 1'b1;
        step();
        check("abort_wr", {31'b0, mem_write}, 32'd0);
        check("abort_ack", {31'b0, d_ack}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        wait_idle(20);

        // Random traffic with occasional resets.
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        rst = 1'b0;
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
